card_board_ctrl: RTL and testbench

- Game-logic stage directly downstream of random_assign in the Card-Flip design.
- Requests a shuffled deal, latches the 16 three-bit card values, and accepts player card selections two at a time.
- Reveals each selected pair for a fixed interval, then compares the pair and either marks it matched or flips it back down.
- Drives face-up/matched masks and counters to the display/score logic; declares a win when all 8 pairs are matched.

---
 rtl/card_pkg.sv | 32 +++
 rtl/card_show_timer.sv | 42 ++++
 rtl/card_board_ctrl.sv | 170 +++++++++++++++++
 tb/tb_card_board_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Purpose: shared types, sizes, FSM state encoding and card-slice helper for the card board controller.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package card_pkg;

   localparam int NUM_CARDS = 16;
   localparam int VAL_W     = 3;
   localparam int NUM_PAIRS = 8;
   localparam int BOARD_W   = NUM_CARDS * VAL_W;

   // Card 0 sits in bits [0:2]; within a card the lowest-numbered bit is the value MSB.
   typedef logic [0:BOARD_W-1] board_t;
   typedef logic [VAL_W-1:0]   card_val_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEAL_REQ,
      ST_DEAL_WAIT,
      ST_FIRST,
      ST_SECOND,
      ST_SHOW,
      ST_CHECK,
      ST_WIN,
      ST_LOSE
   } state_t;

   // Extract the value of card idx from a packed board.
   function automatic card_val_t card_val(input board_t b, input logic [3:0] idx);
      return b[VAL_W*int'(idx) +: VAL_W];
   endfunction

endpackage

// File: rtl/card_show_timer.sv
// Purpose: reveal-interval down-counter; load sets SHOW_CYCLES-1, counts to zero and holds there.
// Latency: zero_o is registered state; asserts SHOW_CYCLES enabled cycles after load.
// Backpressure: none; clear overrides load, load overrides counting.
module card_show_timer #(
   parameter int SHOW_CYCLES = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic clear_i,
   input  logic en_i,
   output logic zero_o
);

   localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   // Next count: clear, reload, or decrement while enabled and not yet at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = TW'(SHOW_CYCLES - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/card_board_ctrl.sv
// Purpose: card-flip game FSM: requests a deal, takes pair picks, reveals, compares, scores (CARD_MOVE_LIMIT_EN adds a move limit and LOSE).
// Latency: picks land on face_up the next edge; a pair is compared SHOW_CYCLES cycles after its second pick.
// Backpressure: none; selections that cannot be accepted are dropped, new_game preempts everything but reset.
module card_board_ctrl
   import card_pkg::*;
#(
   parameter int SHOW_CYCLES = 25000000,
   parameter int MOVE_W      = 8
`ifdef CARD_MOVE_LIMIT_EN
   , parameter int MAX_MOVES = 20
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 new_game,
   output logic                 deal_start,
   input  logic                 deal_done,
   input  logic [0:47]          deal_cards,
   input  logic                 sel_valid,
   input  logic [3:0]           sel_idx,
   output logic [0:47]          board,
   output logic [15:0]          face_up,
   output logic [15:0]          matched,
   output logic [3:0]           pairs_found,
   output logic [MOVE_W-1:0]    moves,
   output logic                 busy,
   output logic                 match_pulse,
   output logic                 miss_pulse,
   output logic                 game_over
`ifdef CARD_MOVE_LIMIT_EN
   , output logic               lost
`endif
);

   state_t              state_q, state_d;
   board_t              board_q, board_d;
   logic [15:0]         face_q, face_d;
   logic [15:0]         matched_q, matched_d;
   logic [3:0]          pairs_q, pairs_d;
   logic [MOVE_W-1:0]   moves_q, moves_d;
   logic [3:0]          a_q, a_d;
   logic [3:0]          b_q, b_d;

   logic                tmr_load, tmr_zero;
   logic                pair_hit;
   logic [MOVE_W-1:0]   moves_inc;

   card_show_timer #(
      .SHOW_CYCLES (SHOW_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (tmr_load),
      .clear_i (new_game),
      .en_i    (state_q == ST_SHOW),
      .zero_o  (tmr_zero)
   );

   assign pair_hit  = (card_val(board_q, a_q) == card_val(board_q, b_q));
   assign moves_inc = (moves_q == {MOVE_W{1'b1}}) ? moves_q : moves_q + MOVE_W'(1);

   // Next-state, mask/counter updates and compare pulses; new_game overrides every state action.
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      face_d      = face_q;
      matched_d   = matched_q;
      pairs_d     = pairs_q;
      moves_d     = moves_q;
      a_d         = a_q;
      b_d         = b_q;
      tmr_load    = 1'b0;
      match_pulse = 1'b0;
      miss_pulse  = 1'b0;
      if (new_game) begin
         state_d   = ST_DEAL_REQ;
         face_d    = '0;
         matched_d = '0;
         pairs_d   = '0;
         moves_d   = '0;
      end else begin
         case (state_q)
            ST_DEAL_REQ: state_d = ST_DEAL_WAIT;
            ST_DEAL_WAIT: begin
               if (deal_done) begin
                  board_d = deal_cards;
                  state_d = ST_FIRST;
               end
            end
            ST_FIRST: begin
               if (sel_valid && !face_q[sel_idx]) begin
                  face_d[sel_idx] = 1'b1;
                  a_d             = sel_idx;
                  state_d         = ST_SECOND;
               end
            end
            ST_SECOND: begin
               if (sel_valid && !face_q[sel_idx]) begin
                  face_d[sel_idx] = 1'b1;
                  b_d             = sel_idx;
                  tmr_load        = 1'b1;
                  state_d         = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (tmr_zero) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               moves_d = moves_inc;
               if (pair_hit) begin
                  matched_d[a_q] = 1'b1;
                  matched_d[b_q] = 1'b1;
                  pairs_d        = pairs_q + 4'd1;
                  match_pulse    = 1'b1;
                  state_d        = (pairs_q == 4'(NUM_PAIRS - 1)) ? ST_WIN : ST_FIRST;
               end else begin
                  face_d[a_q] = 1'b0;
                  face_d[b_q] = 1'b0;
                  miss_pulse  = 1'b1;
                  state_d     = ST_FIRST;
`ifdef CARD_MOVE_LIMIT_EN
                  if (moves_inc == MOVE_W'(MAX_MOVES)) begin
                     face_d  = '1;
                     state_d = ST_LOSE;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // State, board, mask and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         board_q   <= '0;
         face_q    <= '0;
         matched_q <= '0;
         pairs_q   <= '0;
         moves_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         face_q    <= face_d;
         matched_q <= matched_d;
         pairs_q   <= pairs_d;
         moves_q   <= moves_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   assign deal_start  = (state_q == ST_DEAL_REQ);
   assign busy        = (state_q == ST_DEAL_REQ) || (state_q == ST_DEAL_WAIT) ||
                        (state_q == ST_SHOW)     || (state_q == ST_CHECK);
   assign game_over   = (state_q == ST_WIN) || (state_q == ST_LOSE);
   assign board       = board_q;
   assign face_up     = face_q;
   assign matched     = matched_q;
   assign pairs_found = pairs_q;
   assign moves       = moves_q;
`ifdef CARD_MOVE_LIMIT_EN
   assign lost        = (state_q == ST_LOSE);
`endif

endmodule

// File: tb/tb_card_board_ctrl.sv
// Purpose: directed self-checking bench for card_board_ctrl (SHOW_CYCLES=4; CARD_MOVE_LIMIT_EN adds the LOSE scenario).
// Latency: inputs driven 1ns after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_card_board_ctrl;

   logic        clk = 1'b0;
   logic        reset, new_game, deal_done, sel_valid;
   logic [0:47] deal_cards;
   logic [3:0]  sel_idx;
   logic        deal_start, busy, match_pulse, miss_pulse, game_over;
   logic [0:47] board;
   logic [15:0] face_up, matched;
   logic [3:0]  pairs_found;
   logic [7:0]  moves;
`ifdef CARD_MOVE_LIMIT_EN
   logic        lost;
`endif

   logic [0:47] stub;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   card_board_ctrl #(
      .SHOW_CYCLES (4),
      .MOVE_W      (8)
`ifdef CARD_MOVE_LIMIT_EN
      , .MAX_MOVES (2)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .new_game    (new_game),
      .deal_start  (deal_start),
      .deal_done   (deal_done),
      .deal_cards  (deal_cards),
      .sel_valid   (sel_valid),
      .sel_idx     (sel_idx),
      .board       (board),
      .face_up     (face_up),
      .matched     (matched),
      .pairs_found (pairs_found),
      .moves       (moves),
      .busy        (busy),
      .match_pulse (match_pulse),
      .miss_pulse  (miss_pulse),
      .game_over   (game_over)
`ifdef CARD_MOVE_LIMIT_EN
      , .lost      (lost)
`endif
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pick(input logic [3:0] idx);
      sel_valid = 1'b1;
      sel_idx   = idx;
      tick();
      sel_valid = 1'b0;
   endtask

   // new_game, check deal_start next cycle, then land the stub deal.
   task automatic start_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      total++;
      if ({deal_start, busy, face_up, matched, pairs_found, moves} !== {2'b11, 16'h0, 16'h0, 4'd0, 8'd0}) begin
         bad++;
         $display("FAIL start_req ds=%b busy=%b face=%h m=%h p=%0d mv=%0d", deal_start, busy, face_up, matched, pairs_found, moves);
      end
      tick();
      total++;
      if ({deal_start, busy} !== 2'b01) begin
         bad++;
         $display("FAIL start_wait ds=%b busy=%b want ds=0 busy=1", deal_start, busy);
      end
      deal_done  = 1'b1;
      deal_cards = stub;
      tick();
      deal_done  = 1'b0;
      deal_cards = '0;
      total++;
      if ({board, busy, game_over} !== {stub, 2'b00}) begin
         bad++;
         $display("FAIL start_board board=%h busy=%b go=%b want board=%h", board, busy, game_over, stub);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      total++;
      if ({board, face_up, matched, pairs_found, moves, busy, deal_start, match_pulse, miss_pulse, game_over} !== '0) begin
         bad++;
         $display("FAIL reset board=%h face=%h m=%h p=%0d mv=%0d busy=%b ds=%b go=%b",
                  board, face_up, matched, pairs_found, moves, busy, deal_start, game_over);
      end
      // IDLE ignores selections and deal_done
      sel_valid = 1'b1; sel_idx = 4'd3; deal_done = 1'b1; deal_cards = stub;
      tick(2);
      sel_valid = 1'b0; deal_done = 1'b0; deal_cards = '0;
      total++;
      if ({board, face_up, busy} !== '0) begin
         bad++;
         $display("FAIL idle_ignore board=%h face=%h busy=%b want all 0", board, face_up, busy);
      end
   endtask

   task automatic test_match();
      start_game();
      pick(4'd0);
      total++;
      if (face_up !== 16'h0001) begin
         bad++;
         $display("FAIL first_pick face=%h want 0001", face_up);
      end
      pick(4'd1);
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({face_up, busy, match_pulse} !== {16'h0003, 2'b10}) begin
            bad++;
            $display("FAIL show_cyc%0d face=%h busy=%b mp=%b want 0003/1/0", c, face_up, busy, match_pulse);
         end
         tick();
      end
      total++;
      if ({match_pulse, miss_pulse} !== 2'b10) begin
         bad++;
         $display("FAIL match_pulse mp=%b xp=%b want 1/0", match_pulse, miss_pulse);
      end
      tick();
      total++;
      if ({matched, face_up, pairs_found, moves, match_pulse, busy} !== {16'h0003, 16'h0003, 4'd1, 8'd1, 2'b00}) begin
         bad++;
         $display("FAIL match_result m=%h face=%h p=%0d mv=%0d mp=%b", matched, face_up, pairs_found, moves, match_pulse);
      end
   endtask

   task automatic test_miss();
      start_game();
      pick(4'd0);
      pick(4'd2);
      tick(3);
      total++;
      if ({face_up, miss_pulse} !== {16'h0005, 1'b0}) begin
         bad++;
         $display("FAIL miss_show face=%h xp=%b want 0005/0", face_up, miss_pulse);
      end
      tick();
      total++;
      if ({miss_pulse, match_pulse} !== 2'b10) begin
         bad++;
         $display("FAIL miss_pulse xp=%b mp=%b want 1/0", miss_pulse, match_pulse);
      end
      tick();
      total++;
      if ({face_up, matched, moves, pairs_found, miss_pulse} !== {16'h0, 16'h0, 8'd1, 4'd0, 1'b0}) begin
         bad++;
         $display("FAIL miss_result face=%h m=%h mv=%0d p=%0d", face_up, matched, moves, pairs_found);
      end
   endtask

   task automatic test_ignore();
      start_game();
      pick(4'd0);
      pick(4'd1);
      tick(5);
      pick(4'd0);          // matched card in FIRST
      total++;
      if ({face_up, busy} !== {16'h0003, 1'b0}) begin
         bad++;
         $display("FAIL ign_matched face=%h busy=%b want 0003/0", face_up, busy);
      end
      pick(4'd2);
      pick(4'd2);          // re-select A in SECOND
      total++;
      if ({face_up, busy} !== {16'h0007, 1'b0}) begin
         bad++;
         $display("FAIL ign_reselect face=%h busy=%b want 0007/0", face_up, busy);
      end
      pick(4'd3);
      pick(4'd5);          // during SHOW
      total++;
      if ({face_up, busy} !== {16'h000F, 1'b1}) begin
         bad++;
         $display("FAIL ign_show face=%h busy=%b want 000F/1", face_up, busy);
      end
      tick(4);
      total++;
      if ({matched, pairs_found, face_up} !== {16'h000F, 4'd2, 16'h000F}) begin
         bad++;
         $display("FAIL ign_after m=%h p=%0d face=%h want 000F/2/000F", matched, pairs_found, face_up);
      end
   endtask

   // Continues from the game left by test_ignore (pairs 0-1 and 2-3 found, 2 moves).
   task automatic test_win();
      for (int p = 2; p < 8; p++) begin
         pick(4'(2*p));
         pick(4'(2*p+1));
         tick(4);
         if (p == 7) begin
            total++;
            if (match_pulse !== 1'b1) begin
               bad++;
               $display("FAIL win_pulse mp=%b want 1", match_pulse);
            end
         end
         tick();
      end
      total++;
      if ({game_over, pairs_found, matched, moves, busy} !== {1'b1, 4'd8, 16'hFFFF, 8'd8, 1'b0}) begin
         bad++;
         $display("FAIL win go=%b p=%0d m=%h mv=%0d busy=%b want 1/8/FFFF/8/0", game_over, pairs_found, matched, moves, busy);
      end
      pick(4'd4);
      tick(2);
      total++;
      if ({game_over, busy, moves} !== {2'b10, 8'd8}) begin
         bad++;
         $display("FAIL win_ignore go=%b busy=%b mv=%0d want 1/0/8", game_over, busy, moves);
      end
      start_game();
   endtask

   task automatic test_newgame_mid();
      pick(4'd4);
      new_game  = 1'b1;
      sel_valid = 1'b1;
      sel_idx   = 4'd6;
      tick();
      new_game  = 1'b0;
      sel_valid = 1'b0;
      total++;
      if ({deal_start, busy, face_up, board} !== {2'b11, 16'h0, stub}) begin
         bad++;
         $display("FAIL ng_mid ds=%b busy=%b face=%h board=%h", deal_start, busy, face_up, board);
      end
      tick();
      deal_done = 1'b1; deal_cards = stub;
      tick();
      deal_done = 1'b0; deal_cards = '0;
   endtask

`ifdef CARD_MOVE_LIMIT_EN
   task automatic test_lose();
      start_game();
      pick(4'd0); pick(4'd2); tick(5);
      total++;
      if ({lost, moves, face_up} !== {1'b0, 8'd1, 16'h0}) begin
         bad++;
         $display("FAIL lose_first lost=%b mv=%0d face=%h", lost, moves, face_up);
      end
      pick(4'd0); pick(4'd2); tick(4);
      total++;
      if (miss_pulse !== 1'b1) begin
         bad++;
         $display("FAIL lose_pulse xp=%b want 1", miss_pulse);
      end
      tick();
      total++;
      if ({lost, game_over, face_up, moves} !== {2'b11, 16'hFFFF, 8'd2}) begin
         bad++;
         $display("FAIL lose lost=%b go=%b face=%h mv=%0d want 1/1/FFFF/2", lost, game_over, face_up, moves);
      end
      start_game();
      total++;
      if (lost !== 1'b0) begin
         bad++;
         $display("FAIL lose_exit lost=%b want 0", lost);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; new_game = 1'b0; deal_done = 1'b0; sel_valid = 1'b0;
      sel_idx = '0; deal_cards = '0;
      for (int i = 0; i < 16; i++) stub[3*i +: 3] = 3'(i/2);
      test_reset();
      test_match();
      test_miss();
      test_ignore();
      test_win();
      test_newgame_mid();
`ifdef CARD_MOVE_LIMIT_EN
      test_lose();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100us;
      $display("FAIL timeout bench did not finish in 100us");
      $fatal(1, "timeout");
   end

endmodule
